ram_burst_ctrl: RTL and testbench

- Initiator for the team's single-port-per-direction synchronous RAM (4-bit data, 8-bit address, registered read with 1-cycle latency).
- Accepts burst commands over a valid/ready command port.
- Write bursts: takes a data stream and drives the RAM write port.
- Read bursts: drives the RAM read port and returns data on a backpressured stream.
- Sits between stream-producing datapath logic and the RAM.

---
 rtl/ram_burst_ctrl_pkg.sv | 34 +++
 rtl/ram_burst_rdbuf.sv | 63 ++++++
 rtl/ram_burst_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_ram_burst_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_burst_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_burst_ctrl_pkg
// Description : Shared types and constants for the RAM burst controller:
//               FSM state encoding, read-buffer geometry, default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_burst_ctrl_pkg;

    // Default datapath widths
    localparam int DEF_AW = 8;
    localparam int DEF_DW = 4;
    localparam int DEF_LW = 8;

    // Read output buffer geometry; pointers wrap modulo BUF_DEPTH
    localparam int unsigned BUF_DEPTH = 3;
    localparam int          PTR_W     = 2;
    localparam int          CNT_W     = 2;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Advance a buffer pointer, wrapping after the last entry
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

endpackage : ram_burst_ctrl_pkg
`default_nettype wire

// File: rtl/ram_burst_rdbuf.sv
`default_nettype none
// ============================================================================
// Module      : ram_burst_rdbuf
// Description : 3-entry FIFO holding {last, data} read beats between the RAM
//               capture stage and the backpressured read stream.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_burst_rdbuf
    import ram_burst_ctrl_pkg::*;
#(
    parameter int W = DEF_DW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [W-1:0]     push_data_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [W-1:0]     mem_q [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(BUF_DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full buffer is only legal when a pop frees a slot
    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);

    // Pointers and occupancy; reset flushes the buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (w_do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the empty flag hides stale entries
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule : ram_burst_rdbuf
`default_nettype wire

// File: rtl/ram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_burst_ctrl
// Description : Burst initiator for a synchronous RAM with 1-cycle registered
//               read. Write bursts stream data onto the RAM write port; read
//               bursts issue reads with credit-based flow control into a
//               3-entry buffer feeding a backpressured read stream.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_burst_ctrl
    import ram_burst_ctrl_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW,
    parameter int LW = DEF_LW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_write_i,
    input  logic [AW-1:0] cmd_addr_i,
    input  logic [LW-1:0] cmd_len_i,
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    input  logic [DW-1:0] wr_data_i,
    output logic          rd_valid_o,
    input  logic          rd_ready_i,
    output logic [DW-1:0] rd_data_o,
    output logic          rd_last_o,
    output logic          cmd_done_o,
    output logic          ram_write_en_o,
    output logic [AW-1:0] ram_write_addr_o,
    output logic [DW-1:0] ram_write_data_o,
    output logic          ram_read_en_o,
    output logic [AW-1:0] ram_read_addr_o,
    input  logic [DW-1:0] ram_read_data_i
);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] beat_q, beat_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          cmd_done_q, cmd_done_d;
    logic          wen_q, wen_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          ren_q, ren_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic          rlast_q, rlast_d;
    logic          cap_q;
    logic          cap_last_q;
    logic [1:0]    inflight_q, inflight_d;

    logic [DW:0]      w_head;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_wr_hs;
    logic             w_issue;
    logic [2:0]       w_level;

    assign w_wr_hs = wr_valid_i & (state_q == ST_WRITE);
    assign w_pop   = ~w_empty & rd_ready_i;
    // The beat read at the previous edge is on ram_read_data_i now
    assign w_push  = cap_q;

    // Credit check: buffered + in-flight, less the beat leaving this cycle
    assign w_level = 3'(w_count) + 3'(inflight_q) - 3'(w_pop);
    assign w_issue = (state_q == ST_READ) && (w_level < 3'(BUF_DEPTH));

    ram_burst_rdbuf #(
        .W (DW + 1)
    ) u_rdbuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (w_push),
        .push_data_i ({cap_last_q, ram_read_data_i}),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .count_o     (w_count),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    // Next-state, burst bookkeeping and RAM port decode
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        cmd_done_d = 1'b0;
        wen_d      = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        ren_d      = 1'b0;
        raddr_d    = raddr_q;
        rlast_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    addr_d  = cmd_addr_i;
                    len_d   = cmd_len_i;
                    beat_d  = '0;
                    state_d = cmd_write_i ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (w_wr_hs) begin
                    wen_d   = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = wr_data_i;
                    addr_d  = addr_q + AW'(1);
                    beat_d  = beat_q + LW'(1);
                    if (beat_q == len_q) begin
                        cmd_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_READ: begin
                if (w_issue) begin
                    ren_d   = 1'b1;
                    raddr_d = addr_q;
                    rlast_d = (beat_q == len_q);
                    addr_d  = addr_q + AW'(1);
                    beat_d  = beat_q + LW'(1);
                    if (beat_q == len_q) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Done once nothing is in flight and the buffer empties now
                if (inflight_q == 2'd0 && (w_count - CNT_W'(w_pop)) == '0) begin
                    cmd_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
        inflight_d  = inflight_q + 2'(w_issue) - 2'(w_push);
    end

    // All controller state and registered outputs; async reset abandons bursts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            cmd_ready_q <= 1'b0;
            cmd_done_q  <= 1'b0;
            wen_q       <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            ren_q       <= 1'b0;
            raddr_q     <= '0;
            rlast_q     <= 1'b0;
            cap_q       <= 1'b0;
            cap_last_q  <= 1'b0;
            inflight_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            cmd_ready_q <= cmd_ready_d;
            cmd_done_q  <= cmd_done_d;
            wen_q       <= wen_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            ren_q       <= ren_d;
            raddr_q     <= raddr_d;
            rlast_q     <= rlast_d;
            cap_q       <= ren_q;
            cap_last_q  <= rlast_q;
            inflight_q  <= inflight_d;
        end
    end

    assign cmd_ready_o      = cmd_ready_q;
    assign wr_ready_o       = (state_q == ST_WRITE);
    assign cmd_done_o       = cmd_done_q;
    assign ram_write_en_o   = wen_q;
    assign ram_write_addr_o = waddr_q;
    assign ram_write_data_o = wdata_q;
    assign ram_read_en_o    = ren_q;
    assign ram_read_addr_o  = raddr_q;
    assign rd_valid_o       = ~w_empty;
    // Head storage is not reset, so mask it while the buffer is empty
    assign rd_data_o        = w_empty ? '0 : w_head[DW-1:0];
    assign rd_last_o        = w_empty ? 1'b0 : w_head[DW];

    // The credit scheme guarantees a slot for every captured beat
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && w_full && !w_pop));

endmodule : ram_burst_ctrl
`default_nettype wire

// File: tb/tb_ram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_burst_ctrl
// Description : Self-checking bench for ram_burst_ctrl. Plays the RAM, keeps
//               expected write/issue/read-beat queues built from the commands
//               and a shadow memory, and checks every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_burst_ctrl;

    localparam int AW = 8;
    localparam int DW = 4;
    localparam int LW = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } wexp_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } rexp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready, rd_last, cmd_done;
    logic [DW-1:0] rd_data;
    logic          ram_write_en, ram_read_en;
    logic [AW-1:0] ram_write_addr, ram_read_addr;
    logic [DW-1:0] ram_write_data;
    logic [DW-1:0] ram_read_data = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_burst_ctrl #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_valid_i      (cmd_valid),
        .cmd_ready_o      (cmd_ready),
        .cmd_write_i      (cmd_write),
        .cmd_addr_i       (cmd_addr),
        .cmd_len_i        (cmd_len),
        .wr_valid_i       (wr_valid),
        .wr_ready_o       (wr_ready),
        .wr_data_i        (wr_data),
        .rd_valid_o       (rd_valid),
        .rd_ready_i       (rd_ready),
        .rd_data_o        (rd_data),
        .rd_last_o        (rd_last),
        .cmd_done_o       (cmd_done),
        .ram_write_en_o   (ram_write_en),
        .ram_write_addr_o (ram_write_addr),
        .ram_write_data_o (ram_write_data),
        .ram_read_en_o    (ram_read_en),
        .ram_read_addr_o  (ram_read_addr),
        .ram_read_data_i  (ram_read_data)
    );

    function automatic logic [DW-1:0] pat(input int i);
        return DW'(i * 7 + 3);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- RAM model (registered read, 1-cycle latency) --------
    logic [DW-1:0] mem [256];
    bit            mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
            mem_init <= 1'b1;
        end else begin
            if (ram_write_en) mem[ram_write_addr] <= ram_write_data;
        end
        if (ram_read_en) ram_read_data <= mem[ram_read_addr];
    end

    // ---------------- expectation model ----------------------------------
    logic [DW-1:0] shadow [256];
    wexp_t         exp_w[$];
    logic [AW-1:0] exp_raddr[$];
    rexp_t         exp_r[$];

    logic [DW-1:0] got[$];
    logic          got_last[$];
    int            pop_cyc[$];
    int            done_cnt = 0;
    int            issued = 0, popped = 0;
    bit            done_due = 1'b0, stall_prev = 1'b0;
    logic [DW-1:0] stall_d;
    logic          stall_l;

    // Single compare process, sampled on the falling edge
    always @(negedge clk) begin
        bit    exp_done;
        wexp_t wb;
        rexp_t rb;
        if (!rst_n) begin
            exp_w.delete();
            exp_raddr.delete();
            exp_r.delete();
            issued = 0;
            popped = 0;
            done_due = 1'b0;
            stall_prev = 1'b0;
        end else begin
            exp_done = done_due;
            done_due = 1'b0;
            if (ram_write_en) begin
                chk("wr_expected", int'(exp_w.size() != 0), 1);
                if (exp_w.size() != 0) begin
                    wb = exp_w.pop_front();
                    chk("wr_addr", int'(ram_write_addr), int'(wb.addr));
                    chk("wr_data", int'(ram_write_data), int'(wb.data));
                    if (wb.last) exp_done = 1'b1;
                end
            end
            if (ram_read_en) begin
                issued++;
                chk("rd_issue_expected", int'(exp_raddr.size() != 0), 1);
                if (exp_raddr.size() != 0)
                    chk("rd_issue_addr", int'(ram_read_addr), int'(exp_raddr.pop_front()));
            end
            chk("buffered_plus_inflight_le3", int'((issued - popped) <= 3), 1);
            if (stall_prev) chk("valid_held_in_stall", int'(rd_valid), 1);
            if (rd_valid) begin
                if (stall_prev) begin
                    chk("stall_data_stable", int'(rd_data), int'(stall_d));
                    chk("stall_last_stable", int'(rd_last), int'(stall_l));
                end
                if (rd_ready) begin
                    popped++;
                    got.push_back(rd_data);
                    got_last.push_back(rd_last);
                    pop_cyc.push_back(cyc);
                    chk("rd_beat_expected", int'(exp_r.size() != 0), 1);
                    if (exp_r.size() != 0) begin
                        rb = exp_r.pop_front();
                        chk("rd_data", int'(rd_data), int'(rb.data));
                        chk("rd_last", int'(rd_last), int'(rb.last));
                        if (rb.last) done_due = 1'b1;
                    end
                    stall_prev = 1'b0;
                end else begin
                    stall_prev = 1'b1;
                    stall_d = rd_data;
                    stall_l = rd_last;
                end
            end else begin
                stall_prev = 1'b0;
            end
            chk("cmd_done", int'(cmd_done), int'(exp_done));
            if (cmd_done) done_cnt++;
        end
    end

    // ---------------- stimulus helpers -----------------------------------
    logic [DW-1:0] wdat [8];

    task automatic chk_zero(input string name);
        chk(name, int'({cmd_ready, wr_ready, rd_valid, rd_data, rd_last, cmd_done,
                        ram_write_en, ram_write_addr, ram_write_data,
                        ram_read_en, ram_read_addr}), 0);
    endtask

    task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = l;
        forever begin
            @(negedge clk);
            if (cmd_ready || n > 20) break;
            n++;
        end
        chk("cmd_accept_in_time", int'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int limit);
        int k = 0;
        while (done_cnt < target && k < limit) begin
            @(posedge clk);
            #1 k++;
        end
        chk("cmd_done_in_time", int'(done_cnt >= target), 1);
    endtask

    task automatic write_burst(input logic [AW-1:0] a, input int l,
                               input logic [15:0] pbits, input int plen);
        int base = done_cnt;
        int beat = 0;
        int k = 0;
        bit hs;
        for (int i = 0; i <= l; i++) begin
            exp_w.push_back('{addr: AW'(a + i), data: wdat[i], last: (i == l)});
            shadow[AW'(a + i)] = wdat[i];
        end
        send_cmd(1'b1, a, LW'(l));
        while (beat <= l && k < 100) begin
            wr_valid = pbits[k % plen];
            wr_data  = wdat[beat];
            @(negedge clk);
            hs = wr_valid && wr_ready;
            chk("cmd_ready_low_in_write", int'(cmd_ready), 0);
            @(posedge clk);
            #1;
            if (hs) beat++;
            k++;
        end
        wr_valid = 1'b0;
        chk("wr_beats_accepted", beat, l + 1);
        wait_done(base + 1, 20);
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input int l,
                              input logic [15:0] pbits, input int plen, input logic wrv);
        int base = done_cnt;
        int gb = got.size();
        int k = 0;
        for (int i = 0; i <= l; i++) begin
            exp_raddr.push_back(AW'(a + i));
            exp_r.push_back('{data: shadow[AW'(a + i)], last: (i == l)});
        end
        send_cmd(1'b0, a, LW'(l));
        wr_valid = wrv;
        wr_data  = 4'hF;
        while (done_cnt < base + 1 && k < 300) begin
            rd_ready = pbits[k % plen];
            @(posedge clk);
            #1 k++;
        end
        rd_ready = 1'b0;
        wr_valid = 1'b0;
        chk("read_done_in_time", int'(done_cnt >= base + 1), 1);
        chk("read_beat_count", got.size() - gb, l + 1);
    endtask

    // ---------------- main sequence --------------------------------------
    initial begin
        int gb;
        int base;
        int k;
        for (int i = 0; i < 256; i++) shadow[i] = pat(i);
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2 chk_zero("reset_outputs");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Write burst 0x02, 4 beats back-to-back
        wdat[0] = 4'h1; wdat[1] = 4'h2; wdat[2] = 4'h3; wdat[3] = 4'h4;
        write_burst(8'h02, 3, 16'h0001, 1);
        chk("w1_mem02", int'(mem[8'h02]), 4'h1);
        chk("w1_mem03", int'(mem[8'h03]), 4'h2);
        chk("w1_mem04", int'(mem[8'h04]), 4'h3);
        chk("w1_mem05", int'(mem[8'h05]), 4'h4);

        // Read it back with rd_ready high
        gb = got.size();
        read_burst(8'h02, 3, 16'h0001, 1, 1'b0);
        chk("r1_beat0", int'(got[gb]), 4'h1);
        chk("r1_beat3", int'(got[gb + 3]), 4'h4);
        chk("r1_last_on_beat3", int'(got_last[gb + 3]), 1);
        chk("r1_back_to_back", pop_cyc[gb + 3] - pop_cyc[gb], 3);

        // 8-beat read with rd_ready 1,0,0,1 and stray wr_valid held high
        gb = got.size();
        read_burst(8'h10, 7, 16'h0009, 4, 1'b1);
        chk("r8_beat0", int'(got[gb]), 4'h3);
        chk("r8_beat7", int'(got[gb + 7]), 4'h4);
        chk("r8_last", int'(got_last[gb + 7]), 1);

        // Wrapping write with wr_valid gaps 1,0,1,1,0,1
        wdat[0] = 4'h9; wdat[1] = 4'hA; wdat[2] = 4'hB; wdat[3] = 4'hC;
        write_burst(8'hFE, 3, 16'h002D, 6);
        chk("wrap_memFE", int'(mem[8'hFE]), 4'h9);
        chk("wrap_memFF", int'(mem[8'hFF]), 4'hA);
        chk("wrap_mem00", int'(mem[8'h00]), 4'hB);
        chk("wrap_mem01", int'(mem[8'h01]), 4'hC);

        // Reset in the middle of a read burst
        base = done_cnt;
        gb = got.size();
        for (int i = 0; i <= 3; i++) begin
            exp_raddr.push_back(AW'(8'h02 + i));
            exp_r.push_back('{data: shadow[AW'(8'h02 + i)], last: (i == 3)});
        end
        send_cmd(1'b0, 8'h02, 8'd3);
        rd_ready = 1'b1;
        k = 0;
        while (got.size() < gb + 2 && k < 50) begin
            @(posedge clk);
            #1 k++;
        end
        chk("rst_two_beats_seen", int'(got.size() >= gb + 2), 1);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_reset_outputs");
        rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("no_done_after_reset", done_cnt, base);

        // Single-beat write then read at 0x07
        base = done_cnt;
        wdat[0] = 4'hA;
        write_burst(8'h07, 0, 16'h0001, 1);
        gb = got.size();
        read_burst(8'h07, 0, 16'h0001, 1, 1'b0);
        chk("len0_data", int'(got[gb]), 4'hA);
        chk("len0_last", int'(got_last[gb]), 1);
        chk("len0_two_dones", done_cnt - base, 2);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_ram_burst_ctrl
`default_nettype wire
